// File: rtl/disp_frame_fetch_ctrl_if.sv
//==============================================================================
// Module : disp_frame_fetch_ctrl_if
// Brief  : Pixel memory read bus between the frame-fetch scheduler and memory.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface disp_frame_fetch_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 24
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

`default_nettype wire

// File: rtl/disp_frame_fetch_ctrl.sv
//==============================================================================
// Module : disp_frame_fetch_ctrl
// Brief  : Display frame-fetch scheduler. Issues bottom-up BMP pixel reads from
//          sync/de timing, re-aligns sync/de with read data, flags bad frames.
//          Optional macro DISP_FETCH_ERR_CNT_EN adds o_err_cnt.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module disp_frame_fetch_ctrl #(
  parameter int HRES   = 4,
  parameter int VRES   = 4,
  parameter int AW     = 16,
  parameter int DW     = 24,
  parameter int RD_LAT = 1
) (
  input  wire            i_clk,
  input  wire            rst,
  input  wire            i_en,
  input  wire [AW-1:0]   i_base_addr,
  input  wire            i_hsync,
  input  wire            i_vsync,
  input  wire            i_de,
  disp_frame_fetch_ctrl_if.master mem,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_de,
  output logic [DW-1:0]  o_pix,
  output logic           o_frame_err
`ifdef DISP_FETCH_ERR_CNT_EN
  ,
  output logic [15:0]    o_err_cnt
`endif
);

  localparam int CW = $clog2(HRES + 1);
  localparam int LW = $clog2(VRES + 3);

  localparam logic [AW-1:0] C_HRES_AW      = AW'(HRES);
  localparam logic [AW-1:0] C_LAST_ROW_OFS = AW'((VRES - 1) * HRES);
  localparam logic [CW-1:0] C_HRES_CW      = CW'(HRES);
  localparam logic [LW-1:0] C_VRES_LW      = LW'(VRES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_vsync_d;
  logic            r_de_d;
  logic [AW-1:0]   r_row_base;
  logic [CW-1:0]   r_col;
  logic [LW-1:0]   r_line;
  logic            r_rd_en;
  logic [AW-1:0]   r_rd_addr;
  logic            r_frame_err;
  logic [RD_LAT:0] r_hs_pipe;
  logic [RD_LAT:0] r_vs_pipe;
  logic [RD_LAT:0] r_de_pipe;
  logic [RD_LAT:0] r_vld_pipe;
`ifdef DISP_FETCH_ERR_CNT_EN
  logic [15:0]     r_err_cnt;
`endif

  logic          w_fs;
  logic          w_de_fall;
  logic          w_fetching;
  logic          w_in_range;
  logic          w_issue;
  logic [LW-1:0] w_line_end;
  logic          w_end_err;

  assign w_fs       = i_vsync & ~r_vsync_d;
  assign w_de_fall  = ~i_de & r_de_d;
  assign w_fetching = (r_state != ST_IDLE);
  assign w_in_range = (r_col < C_HRES_CW) && (r_line < C_VRES_LW);
  assign w_issue    = w_fetching & ~w_fs & i_de & w_in_range;

  // A line cut short by vsync while de is still high still counts as a line.
  assign w_line_end = r_line + {{(LW-1){1'b0}}, (r_state == ST_ACTIVE)};
  assign w_end_err  = w_fetching && (w_line_end != C_VRES_LW);

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vsync_d   <= 1'b0;
      r_de_d      <= 1'b0;
      r_row_base  <= '0;
      r_col       <= '0;
      r_line      <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_frame_err <= 1'b0;
      r_hs_pipe   <= '0;
      r_vs_pipe   <= '0;
      r_de_pipe   <= '0;
      r_vld_pipe  <= '0;
`ifdef DISP_FETCH_ERR_CNT_EN
      r_err_cnt   <= '0;
`endif
    end else begin
      r_vsync_d  <= i_vsync;
      r_de_d     <= i_de;
      r_hs_pipe  <= {r_hs_pipe[RD_LAT-1:0], i_hsync};
      r_vs_pipe  <= {r_vs_pipe[RD_LAT-1:0], i_vsync};
      r_de_pipe  <= {r_de_pipe[RD_LAT-1:0], i_de};
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_issue};
      r_rd_en    <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_row_base + AW'(r_col);
      end

      if (w_fs) begin
        // End check of the previous frame replaces any error it accumulated.
        r_frame_err <= w_end_err;
`ifdef DISP_FETCH_ERR_CNT_EN
        if (w_end_err && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
`endif
        r_row_base <= i_base_addr + C_LAST_ROW_OFS;
        r_col      <= '0;
        r_line     <= '0;
        r_state    <= i_en ? ST_VBLANK : ST_IDLE;
      end else if (w_fetching) begin
        case (r_state)
          ST_VBLANK: if (i_de)  r_state <= ST_ACTIVE;
          ST_ACTIVE: if (!i_de) r_state <= ST_HBLANK;
          ST_HBLANK: if (i_de)  r_state <= ST_ACTIVE;
          default:              r_state <= ST_IDLE;
        endcase

        if (i_de) begin
          if (w_in_range) begin
            r_col <= r_col + CW'(1);
          end else begin
            r_frame_err <= 1'b1;
          end
        end

        if (w_de_fall) begin
          r_row_base <= r_row_base - C_HRES_AW;
          r_col      <= '0;
          if (r_line <= C_VRES_LW) begin
            r_line <= r_line + LW'(1);
          end
          if (r_col != C_HRES_CW) begin
            r_frame_err <= 1'b1;
          end
        end
      end
    end
  end

  assign mem.rd_en   = r_rd_en;
  assign mem.rd_addr = r_rd_addr;

  assign o_hsync     = r_hs_pipe[RD_LAT];
  assign o_vsync     = r_vs_pipe[RD_LAT];
  assign o_de        = r_de_pipe[RD_LAT];
  assign o_pix       = r_vld_pipe[RD_LAT] ? mem.rd_data : '0;
  assign o_frame_err = r_frame_err;
`ifdef DISP_FETCH_ERR_CNT_EN
  assign o_err_cnt   = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_disp_frame_fetch_ctrl.sv
//==============================================================================
// Module : tb_disp_frame_fetch_ctrl
// Brief  : Directed self-checking bench for disp_frame_fetch_ctrl (4x4, RD_LAT=1).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_disp_frame_fetch_ctrl;
  localparam int HRES = 4;
  localparam int VRES = 4;
  localparam int AW   = 16;
  localparam int DW   = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] base;
  logic          hs, vs, de;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_hsync, o_vsync, o_de, o_frame_err;
  logic [DW-1:0] o_pix;
`ifdef DISP_FETCH_ERR_CNT_EN
  logic [15:0]   o_err_cnt;
`endif

  disp_frame_fetch_ctrl_if #(.AW(AW), .DW(DW)) mem_if ();

  disp_frame_fetch_ctrl #(
    .HRES(HRES), .VRES(VRES), .AW(AW), .DW(DW), .RD_LAT(1)
  ) dut (
    .i_clk       (clk),
    .rst         (rst),
    .i_en        (en),
    .i_base_addr (base),
    .i_hsync     (hs),
    .i_vsync     (vs),
    .i_de        (de),
    .mem         (mem_if),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_de        (o_de),
    .o_pix       (o_pix),
    .o_frame_err (o_frame_err)
`ifdef DISP_FETCH_ERR_CNT_EN
    ,
    .o_err_cnt   (o_err_cnt)
`endif
  );

  assign o_rd_en   = mem_if.rd_en;
  assign o_rd_addr = mem_if.rd_addr;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8], a[7:0]};
  endfunction

  // One-cycle memory; idle cycles return junk so unmasked pixels show up.
  always @(posedge clk) begin
    if (mem_if.rd_en) mem_if.rd_data <= mem_word(mem_if.rd_addr);
    else              mem_if.rd_data <= 24'hBADBAD;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] pix_q[$];
  logic err_any, err_all, vs_o_d, hs_o_d;
  int   rd_first, de_first, de_in_first;
  int   vs_in_rise, hs_in_rise, vs_out_rise, hs_out_rise;

  always @(negedge clk) begin
    if (o_rd_en) begin
      rd_q.push_back(o_rd_addr);
      if (rd_first < 0) rd_first = cyc;
    end
    if (o_de) begin
      pix_q.push_back(o_pix);
      if (de_first < 0) de_first = cyc;
    end
    err_any = err_any | o_frame_err;
    err_all = err_all & o_frame_err;
    if (o_vsync && !vs_o_d) vs_out_rise = cyc;
    if (o_hsync && !hs_o_d) hs_out_rise = cyc;
    vs_o_d = o_vsync;
    hs_o_d = o_hsync;
  end

  task automatic drive(input logic h, input logic v, input logic d);
    @(posedge clk);
    #1;
    if (v && !vs) vs_in_rise = cyc;
    if (h && !hs) hs_in_rise = cyc;
    if (d && !de && de_in_first < 0) de_in_first = cyc;
    hs = h;
    vs = v;
    de = d;
  endtask

  task automatic clear_trk();
    rd_q.delete();
    pix_q.delete();
    err_any     = 1'b0;
    err_all     = 1'b1;
    rd_first    = -1;
    de_first    = -1;
    de_in_first = -1;
  endtask

  task automatic run_frame(input int nlines, input int long_line, input int long_len,
                           input int rst_line, input int tog_line);
    drive(0, 1, 0);
    drive(0, 1, 0);
    clear_trk();
    drive(0, 0, 0);
    drive(0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      int n;
      if (l == tog_line) begin
        en   = 1'b0;
        base = 16'h0200;
      end
      n = (l == long_line) ? long_len : HRES;
      drive(1, 0, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
      for (int p = 0; p < n; p++) begin
        drive(0, 0, 1);
        if (l == rst_line && p == 2) begin
          rst = 1'b1;
          #1;
          chk("t6_rst_rd_en", 32'(o_rd_en), 32'd0);
          chk("t6_rst_addr",  32'(o_rd_addr), 32'd0);
          chk("t6_rst_de",    32'(o_de), 32'd0);
          chk("t6_rst_pix",   32'(o_pix), 32'd0);
          chk("t6_rst_sync",  32'({o_hsync, o_vsync}), 32'd0);
          chk("t6_rst_err",   32'(o_frame_err), 32'd0);
          @(posedge clk);
          #1 rst = 1'b0;
        end
      end
      drive(0, 0, 0);
      drive(0, 0, 0);
    end
    drive(0, 0, 0);
  endtask

  task automatic check_fetch(input string tag, input int nlines, input int long_line,
                             input int long_len, input logic [AW-1:0] b);
    int k;
    int npix;
    logic [AW-1:0] a;
    npix = nlines * HRES + ((long_line >= 0) ? (long_len - HRES) : 0);
    chk({tag, "_nrd"},  32'(rd_q.size()),  32'(nlines * HRES));
    chk({tag, "_npix"}, 32'(pix_q.size()), 32'(npix));
    k = 0;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < HRES; c++) begin
        a = b + AW'((VRES - 1 - l) * HRES + c);
        if (k < rd_q.size()) chk({tag, "_addr"}, 32'(rd_q[k]), 32'(a));
        k++;
      end
    end
    k = 0;
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < ((l == long_line) ? long_len : HRES); p++) begin
        a = b + AW'((VRES - 1 - l) * HRES + p);
        if (k < pix_q.size())
          chk({tag, "_pix"}, 32'(pix_q[k]), (p < HRES) ? 32'(mem_word(a)) : 32'd0);
        k++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; base = '0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    vs_o_d = 1'b0; hs_o_d = 1'b0;
    vs_in_rise = 0; hs_in_rise = 0; vs_out_rise = 0; hs_out_rise = 0;
    clear_trk();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(o_rd_en), 32'd0);
    chk("rst_addr",  32'(o_rd_addr), 32'd0);
    chk("rst_outs",  32'({o_hsync, o_vsync, o_de, o_frame_err}), 32'd0);
    chk("rst_pix",   32'(o_pix), 32'd0);
`ifdef DISP_FETCH_ERR_CNT_EN
    chk("rst_cnt",   32'(o_err_cnt), 32'd0);
`endif
    rst = 1'b0; en = 1'b1; base = 16'h0100;

    // Normal frame plus latency
    run_frame(4, -1, 0, -1, -1);
    check_fetch("t1", 4, -1, 0, 16'h0100);
    chk("t1_err",    32'(err_any), 32'd0);
    chk("t2_rd_lat", 32'(rd_first - de_in_first), 32'd1);
    chk("t2_de_lat", 32'(de_first - de_in_first), 32'd2);
    chk("t2_vs_lat", 32'(vs_out_rise - vs_in_rise), 32'd2);
    chk("t2_hs_lat", 32'(hs_out_rise - hs_in_rise), 32'd2);

    // Disabled frame: timing passes through, no reads, blank pixels
    en = 1'b0;
    run_frame(4, -1, 0, -1, -1);
    chk("t3_off_nrd",  32'(rd_q.size()), 32'd0);
    chk("t3_off_npix", 32'(pix_q.size()), 32'd16);
    for (int i = 0; i < pix_q.size(); i++) chk("t3_off_pix", 32'(pix_q[i]), 32'd0);
    chk("t3_off_err",  32'(err_any), 32'd0);

    // Enabled frame with mid-frame en/base change
    en = 1'b1;
    run_frame(4, -1, 0, -1, 1);
    check_fetch("t3", 4, -1, 0, 16'h0100);
    chk("t3_err", 32'(err_any), 32'd0);
    en = 1'b1; base = 16'h0100;

    // Line with 6 de cycles
    run_frame(4, 1, 6, -1, -1);
    check_fetch("t4", 4, 1, 6, 16'h0100);
    chk("t4_err_held", 32'(o_frame_err), 32'd1);

    // Short frame: error appears only at the following frame start
    run_frame(3, -1, 0, -1, -1);
    check_fetch("t5a", 3, -1, 0, 16'h0100);
    chk("t5_err_cleared", 32'(err_any), 32'd0);
    run_frame(4, -1, 0, -1, -1);
    check_fetch("t5b", 4, -1, 0, 16'h0100);
    chk("t5_err_whole", 32'(err_all), 32'd1);
`ifdef DISP_FETCH_ERR_CNT_EN
    chk("t5_cnt", 32'(o_err_cnt), 32'd1);
`endif

    // Reset in the middle of line 2, then a clean frame
    run_frame(4, -1, 0, 1, -1);
    run_frame(4, -1, 0, -1, -1);
    check_fetch("t6", 4, -1, 0, 16'h0100);
    chk("t6_err", 32'(err_any), 32'd0);
`ifdef DISP_FETCH_ERR_CNT_EN
    chk("t6_cnt", 32'(o_err_cnt), 32'd0);
`endif

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
